// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file write-back types and constants
package regfile_pkg;

    localparam int REG_ADDR_W = 6;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;
    localparam int REG_IDX_W  = $clog2(REG_COUNT);

    localparam int WB_ALU  = 0;
    localparam int WB_FPU  = 1;
    localparam int WB_LOAD = 2;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
        logic                  is_float;
    } wb_req_t;

endpackage

// File: rtl/rr_grant.sv
// rtl/rr_grant.sv - NREQ-wide priority picker, search starts at ptr+1 modulo NREQ
module rr_grant #(
    parameter int NREQ = 3,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant
);

    int idx;

    // Walk from the farthest candidate to the nearest so the nearest requester overwrites.
    always_comb begin
        grant = '0;
        idx   = 0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-back arbiter with registered write port
// WB_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority, requester 0 highest.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic [NREQ-1:0]          req_float,
    input  logic                     hold,
    output logic [ADDR_W-1:0]        wr_reg,
    output logic [DATA_W-1:0]        wr_data,
    output logic                     reg_write,
    output logic                     wr_float,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     err
);

    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  win_idx;
    logic              transfer;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              win_float;
    logic              drop_zero;
    logic              drop_range;

`ifdef WB_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= IDX_W'(NREQ - 1);
        end else if (transfer) begin
            rr_ptr <= win_idx;
        end
    end

    assign ptr = rr_ptr;
`else
    assign ptr = IDX_W'(NREQ - 1);
`endif

    rr_grant #(
        .NREQ (NREQ)
    ) u_rr_grant (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = (rst || hold) ? '0 : grant;
    assign transfer  = |(req_valid & req_ready);

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign win_addr  = req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
    assign win_data  = req_data[int'(win_idx)*DATA_W +: DATA_W];
    assign win_float = req_float[win_idx];

    // Each bank holds REG_COUNT entries; any higher address bit set is illegal.
    assign drop_range = (win_addr >> REG_IDX_W) != '0;
    assign drop_zero  = !win_float && (win_addr == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write <= 1'b0;
            wr_reg    <= '0;
            wr_data   <= '0;
            wr_float  <= 1'b0;
            grant_id  <= '0;
            err       <= 1'b0;
        end else begin
            reg_write <= transfer && !drop_zero && !drop_range;
            if (transfer) begin
                wr_reg   <= win_addr;
                wr_data  <= win_data;
                wr_float <= win_float;
                grant_id <= win_idx;
                if (drop_range) begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_float;
    logic                   hold;
    logic [ADDR_W-1:0]      wr_reg;
    logic [DATA_W-1:0]      wr_data;
    logic                   reg_write;
    logic                   wr_float;
    logic [1:0]             grant_id;
    logic                   err;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(
        .NREQ   (NREQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_float (req_float),
        .hold      (hold),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .reg_write (reg_write),
        .wr_float  (wr_float),
        .grant_id  (grant_id),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input int i, input wb_req_t r);
        req_addr[i*ADDR_W +: ADDR_W] = r.addr;
        req_data[i*DATA_W +: DATA_W] = r.data;
        req_float[i]                 = r.is_float;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [1:0] exp_id [6];

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        req_float = '0;
        hold      = 1'b0;
        tick();
        tick();

        // Ready must stay low while reset is held even with a valid request.
        req_valid = 3'b001;
        #1;
        chk("ready_in_rst", req_ready, 3'b000);
        req_valid = '0;
        rst = 1'b0;
        #1;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_wr_float", wr_float, 0);
        chk("rst_grant_id", grant_id, 0);
        chk("rst_err", err, 0);

        // Single request on the FPU slot.
        put(WB_FPU, '{addr: 6'd5, data: 32'hDEADBEEF, is_float: 1'b0});
        req_valid = 3'b010;
        #1;
        chk("single_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        chk("single_reg_write", reg_write, 1);
        chk("single_wr_reg", wr_reg, 5);
        chk("single_wr_data", wr_data, 64'hDEADBEEF);
        chk("single_wr_float", wr_float, 0);
        chk("single_grant_id", grant_id, 1);
        tick();
        chk("single_reg_write_end", reg_write, 0);
        chk("single_wr_reg_hold", wr_reg, 5);

        // Contention from a fresh pointer.
        pulse_reset();
`ifdef WB_ARB_RR_EN
        exp_id = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
`else
        exp_id = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        put(WB_ALU,  '{addr: 6'd1, data: 32'h1111_0000, is_float: 1'b0});
        put(WB_FPU,  '{addr: 6'd2, data: 32'h2222_0000, is_float: 1'b1});
        put(WB_LOAD, '{addr: 6'd3, data: 32'h3333_0000, is_float: 1'b0});
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("cont_ready_%0d", c), req_ready, 3'b001 << exp_id[c]);
            tick();
            chk($sformatf("cont_reg_write_%0d", c), reg_write, 1);
            chk($sformatf("cont_grant_%0d", c), grant_id, exp_id[c]);
            chk($sformatf("cont_wr_reg_%0d", c), wr_reg, exp_id[c] + 1);
        end
        req_valid = '0;
        tick();
        chk("cont_idle", reg_write, 0);

        // Integer $zero write is dropped silently.
        put(WB_ALU, '{addr: 6'd0, data: 32'h0000_1234, is_float: 1'b0});
        req_valid = 3'b001;
        #1;
        chk("zero_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("zero_reg_write", reg_write, 0);
        chk("zero_err", err, 0);

        // Float register 0 is a real register.
        put(WB_ALU, '{addr: 6'd0, data: 32'h0000_0055, is_float: 1'b1});
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        chk("fzero_reg_write", reg_write, 1);
        chk("fzero_wr_float", wr_float, 1);
        chk("fzero_wr_data", wr_data, 32'h55);

        // Hold blocks grants; release grants in the same cycle.
        put(WB_ALU, '{addr: 6'd7, data: 32'h0000_0077, is_float: 1'b0});
        req_valid = 3'b001;
        hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold_ready_%0d", c), req_ready, 3'b000);
            tick();
            chk($sformatf("hold_reg_write_%0d", c), reg_write, 0);
        end
        hold = 1'b0;
        #1;
        chk("unhold_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("unhold_reg_write", reg_write, 1);
        chk("unhold_wr_reg", wr_reg, 7);

        // A write already registered completes under hold.
        put(WB_ALU, '{addr: 6'd8, data: 32'h0000_0088, is_float: 1'b0});
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        hold = 1'b1;
        chk("inflight_reg_write", reg_write, 1);
        chk("inflight_wr_reg", wr_reg, 8);
        tick();
        chk("inflight_done", reg_write, 0);
        hold = 1'b0;

        // Out-of-range address: handshake completes, write dropped, err sticks.
        put(WB_LOAD, '{addr: 6'd40, data: 32'h0000_0040, is_float: 1'b0});
        req_valid = 3'b100;
        #1;
        chk("range_ready", req_ready, 3'b100);
        tick();
        req_valid = '0;
        chk("range_reg_write", reg_write, 0);
        chk("range_err", err, 1);
        chk("range_grant_id", grant_id, 2);
        put(WB_ALU, '{addr: 6'd9, data: 32'h0000_0099, is_float: 1'b0});
        req_valid = 3'b001;
        tick();
        req_valid = '0;
        chk("range_next_write", reg_write, 1);
        chk("range_err_sticky", err, 1);

        // Reset in the cycle after a transfer cancels the pending write.
        put(WB_FPU, '{addr: 6'd12, data: 32'h0000_00CC, is_float: 1'b0});
        req_valid = 3'b010;
        tick();
        rst = 1'b1;
        #1;
        chk("midrst_ready", req_ready, 3'b000);
        tick();
        chk("midrst_reg_write", reg_write, 0);
        chk("midrst_wr_reg", wr_reg, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_grant_id", grant_id, 0);
        chk("midrst_err", err, 0);
        rst = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("post_rst_ready", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("post_rst_grant", grant_id, 0);
        chk("post_rst_reg_write", reg_write, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
